// File: rtl/slice_sequencer.sv
// slice_sequencer: control sequencer for one sigma-delta filter slice.
// On each sample tick it sweeps coefficient/state addresses across all taps,
// drains the slice pipeline and fires the output triggers. Between passes it
// runs state read-back sweeps and accepts host coefficient writes, so the
// slice RAMs only ever see one source at a time.
//
// Handshake: a host write transfers on a rising clock edge where both
// coef_wr_valid and coef_wr_ready are high. The host holds adr/data stable
// while valid is high. coef_wr_ready is combinational and never depends on
// coef_wr_valid.
module slice_sequencer #(
  parameter int NUM_TAPS    = 10,
  parameter int COEF_ADR_W  = 9,
  parameter int STATE_ADR_W = 4,
  parameter int RD_DELAY    = 1,
  parameter int WR_DELAY    = 3,
  parameter int RB_LATENCY  = 2
) (
  input  logic                   clock_200,
  input  logic                   reset,
  input  logic                   sample_tick,
  input  logic [COEF_ADR_W-1:0]  coef_base,
  input  logic                   log_enable,
  input  logic                   coef_wr_valid,
  output logic                   coef_wr_ready,
  input  logic [COEF_ADR_W-1:0]  coef_wr_adr,
  input  logic [35:0]            coef_wr_data,
  input  logic                   readback_req,
  output logic                   slice_enable,
  output logic                   read_back,
  output logic [COEF_ADR_W-1:0]  coefficient_read_adr,
  output logic [COEF_ADR_W-1:0]  coefficient_write_adr,
  output logic [35:0]            coefficient_write_data,
  output logic                   coefficient_write_en,
  output logic [STATE_ADR_W-1:0] state_read_adr,
  output logic [STATE_ADR_W-1:0] state_write_adr,
  output logic                   sigma_delta_out_trigger,
  output logic                   log_trigger,
  output logic                   rb_valid,
  output logic [STATE_ADR_W-1:0] rb_index,
  output logic                   rb_abort,
  output logic                   busy,
  output logic                   overrun,
  output logic [2:0]             state_dbg
);

  localparam int DLY_A   = (RD_DELAY > WR_DELAY) ? RD_DELAY : WR_DELAY;
  localparam int DLY_LEN = (DLY_A > RB_LATENCY) ? DLY_A : RB_LATENCY;
  localparam int DRAIN_W = (WR_DELAY > 1) ? $clog2(WR_DELAY) : 1;
  localparam logic [STATE_ADR_W-1:0] LAST_TAP   = STATE_ADR_W'(NUM_TAPS - 1);
  localparam logic [DRAIN_W-1:0]     LAST_DRAIN = DRAIN_W'(WR_DELAY - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RUN      = 3'd1,
    S_DRAIN    = 3'd2,
    S_DONE     = 3'd3,
    S_READBACK = 3'd4
  } state_t;

  state_t                              state_q, state_d;
  logic [STATE_ADR_W-1:0]              tap_q, tap_d;
  logic [DRAIN_W-1:0]                  drain_q, drain_d;
  logic [COEF_ADR_W-1:0]               base_q, base_d;
  logic                                log_en_q, log_en_d;
  logic [DLY_LEN-1:0][STATE_ADR_W-1:0] tap_dly_q, tap_dly_d;
  logic [RB_LATENCY-1:0]               rbv_q, rbv_d;
  logic                                rb_flush;
  logic                                slice_en_q, slice_en_d;
  logic                                read_back_q, read_back_d;
  logic [COEF_ADR_W-1:0]               rd_adr_q, rd_adr_d;
  logic [COEF_ADR_W-1:0]               wr_adr_q, wr_adr_d;
  logic [35:0]                         wr_data_q, wr_data_d;
  logic                                wr_en_q, wr_en_d;
  logic                                trig_q, trig_d;
  logic                                log_trig_q, log_trig_d;
  logic                                abort_q, abort_d;
  logic                                busy_q, busy_d;
  logic                                overrun_q, overrun_d;

  // Host writes are only offered in IDLE when neither a pass nor a read-back
  // is about to start, so a write never lands while the slice RAMs are busy.
  assign coef_wr_ready = (state_q == S_IDLE) && !sample_tick && !readback_req;

  // Next-state, counters, latched pass parameters and registered-output values.
  always_comb begin
    state_d   = state_q;
    tap_d     = tap_q;
    drain_d   = drain_q;
    base_d    = base_q;
    log_en_d  = log_en_q;
    overrun_d = overrun_q;
    abort_d   = 1'b0;
    rb_flush  = 1'b0;
    wr_en_d   = 1'b0;
    wr_adr_d  = wr_adr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      S_IDLE: begin
        if (sample_tick) begin
          state_d  = S_RUN;
          tap_d    = '0;
          base_d   = coef_base;
          log_en_d = log_enable;
        end else if (readback_req) begin
          state_d = S_READBACK;
          tap_d   = '0;
          base_d  = coef_base;
        end else if (coef_wr_valid) begin
          wr_en_d   = 1'b1;
          wr_adr_d  = coef_wr_adr;
          wr_data_d = coef_wr_data;
        end
      end
      S_RUN: begin
        if (sample_tick) overrun_d = 1'b1;
        if (tap_q == LAST_TAP) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else begin
          tap_d = tap_q + STATE_ADR_W'(1);
        end
      end
      S_DRAIN: begin
        if (sample_tick) overrun_d = 1'b1;
        if (drain_q == LAST_DRAIN) state_d = S_DONE;
        else drain_d = drain_q + DRAIN_W'(1);
      end
      S_DONE: begin
        if (sample_tick) overrun_d = 1'b1;
        state_d = S_IDLE;
      end
      S_READBACK: begin
        if (sample_tick) begin
          // A tick preempts the sweep: start the pass exactly as from IDLE.
          state_d  = S_RUN;
          tap_d    = '0;
          base_d   = coef_base;
          log_en_d = log_enable;
          abort_d  = 1'b1;
          rb_flush = 1'b1;
        end else if (tap_q == LAST_TAP) begin
          state_d = S_IDLE;
        end else begin
          tap_d = tap_q + STATE_ADR_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    slice_en_d  = (state_d == S_RUN) || (state_d == S_DRAIN);
    read_back_d = (state_d == S_READBACK);
    busy_d      = (state_d != S_IDLE);
    trig_d      = (state_d == S_DONE);
    log_trig_d  = (state_d == S_DONE) && log_en_d;
    if ((state_d == S_RUN) || (state_d == S_READBACK))
      rd_adr_d = base_d + COEF_ADR_W'(tap_d);
    else
      rd_adr_d = rd_adr_q;

    // Tap delay line runs every cycle; read-back valid line is flushed on abort.
    tap_dly_d[0] = tap_q;
    for (int i = 1; i < DLY_LEN; i++) tap_dly_d[i] = tap_dly_q[i-1];
    rbv_d[0] = (state_q == S_READBACK) && !rb_flush;
    for (int i = 1; i < RB_LATENCY; i++) rbv_d[i] = rbv_q[i-1] && !rb_flush;
  end

  // FSM and all registered outputs; synchronous reset clears everything.
  always_ff @(posedge clock_200) begin
    if (reset) begin
      state_q     <= S_IDLE;
      tap_q       <= '0;
      drain_q     <= '0;
      base_q      <= '0;
      log_en_q    <= 1'b0;
      tap_dly_q   <= '0;
      rbv_q       <= '0;
      slice_en_q  <= 1'b0;
      read_back_q <= 1'b0;
      rd_adr_q    <= '0;
      wr_adr_q    <= '0;
      wr_data_q   <= '0;
      wr_en_q     <= 1'b0;
      trig_q      <= 1'b0;
      log_trig_q  <= 1'b0;
      abort_q     <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tap_q       <= tap_d;
      drain_q     <= drain_d;
      base_q      <= base_d;
      log_en_q    <= log_en_d;
      tap_dly_q   <= tap_dly_d;
      rbv_q       <= rbv_d;
      slice_en_q  <= slice_en_d;
      read_back_q <= read_back_d;
      rd_adr_q    <= rd_adr_d;
      wr_adr_q    <= wr_adr_d;
      wr_data_q   <= wr_data_d;
      wr_en_q     <= wr_en_d;
      trig_q      <= trig_d;
      log_trig_q  <= log_trig_d;
      abort_q     <= abort_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  assign slice_enable            = slice_en_q;
  assign read_back               = read_back_q;
  assign coefficient_read_adr    = rd_adr_q;
  assign coefficient_write_adr   = wr_adr_q;
  assign coefficient_write_data  = wr_data_q;
  assign coefficient_write_en    = wr_en_q;
  assign state_read_adr          = tap_dly_q[RD_DELAY-1];
  assign state_write_adr         = tap_dly_q[WR_DELAY-1];
  assign sigma_delta_out_trigger = trig_q;
  assign log_trigger             = log_trig_q;
  assign rb_valid                = rbv_q[RB_LATENCY-1];
  assign rb_index                = tap_dly_q[RB_LATENCY-1];
  assign rb_abort                = abort_q;
  assign busy                    = busy_q;
  assign overrun                 = overrun_q;
  assign state_dbg               = state_q;

endmodule

// File: tb/tb_slice_sequencer.sv
// Directed testbench for slice_sequencer. Cycle c of a pass or sweep is the
// value seen between the edge c-1 and edge c after the starting edge.
`timescale 1ns/1ps
module tb_slice_sequencer;
  localparam int NUM_TAPS    = 10;
  localparam int COEF_ADR_W  = 9;
  localparam int STATE_ADR_W = 4;

  logic                   clock_200 = 1'b0;
  logic                   reset;
  logic                   sample_tick;
  logic [COEF_ADR_W-1:0]  coef_base;
  logic                   log_enable;
  logic                   coef_wr_valid;
  logic                   coef_wr_ready;
  logic [COEF_ADR_W-1:0]  coef_wr_adr;
  logic [35:0]            coef_wr_data;
  logic                   readback_req;
  logic                   slice_enable;
  logic                   read_back;
  logic [COEF_ADR_W-1:0]  coefficient_read_adr;
  logic [COEF_ADR_W-1:0]  coefficient_write_adr;
  logic [35:0]            coefficient_write_data;
  logic                   coefficient_write_en;
  logic [STATE_ADR_W-1:0] state_read_adr;
  logic [STATE_ADR_W-1:0] state_write_adr;
  logic                   sigma_delta_out_trigger;
  logic                   log_trigger;
  logic                   rb_valid;
  logic [STATE_ADR_W-1:0] rb_index;
  logic                   rb_abort;
  logic                   busy;
  logic                   overrun;
  logic [2:0]             state_dbg;

  int tests_run    = 0;
  int tests_failed = 0;

  slice_sequencer dut (
    .clock_200(clock_200), .reset(reset), .sample_tick(sample_tick),
    .coef_base(coef_base), .log_enable(log_enable),
    .coef_wr_valid(coef_wr_valid), .coef_wr_ready(coef_wr_ready),
    .coef_wr_adr(coef_wr_adr), .coef_wr_data(coef_wr_data),
    .readback_req(readback_req), .slice_enable(slice_enable), .read_back(read_back),
    .coefficient_read_adr(coefficient_read_adr), .coefficient_write_adr(coefficient_write_adr),
    .coefficient_write_data(coefficient_write_data), .coefficient_write_en(coefficient_write_en),
    .state_read_adr(state_read_adr), .state_write_adr(state_write_adr),
    .sigma_delta_out_trigger(sigma_delta_out_trigger), .log_trigger(log_trigger),
    .rb_valid(rb_valid), .rb_index(rb_index), .rb_abort(rb_abort),
    .busy(busy), .overrun(overrun), .state_dbg(state_dbg)
  );

  // Clock: 200 MHz.
  always #2.5 clock_200 = ~clock_200;

  // Advance one edge; outputs are then read 1 ns later, away from the edge.
  task automatic step();
    @(posedge clock_200);
    #1;
  endtask

  // All registered outputs packed together for the all-zero reset check.
  function automatic logic [77:0] out_vec();
    return {slice_enable, read_back, coefficient_read_adr, coefficient_write_adr,
            coefficient_write_data, coefficient_write_en, state_read_adr, state_write_adr,
            sigma_delta_out_trigger, log_trigger, rb_valid, rb_index, rb_abort,
            busy, overrun, state_dbg};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; sample_tick = 1'b0; coef_base = '0; log_enable = 1'b0;
    coef_wr_valid = 1'b0; coef_wr_adr = '0; coef_wr_data = '0; readback_req = 1'b0;
    repeat (3) step();
    tests_run++;
    if (out_vec() !== 78'd0) begin
      tests_failed++; $display("FAIL reset_outputs got %h exp 0", out_vec());
    end
    reset = 1'b0;
    step();
    tests_run++;
    if (out_vec() !== 78'd0) begin
      tests_failed++; $display("FAIL idle_outputs got %h exp 0", out_vec());
    end
    tests_run++;
    if (coef_wr_ready !== 1'b1) begin
      tests_failed++; $display("FAIL idle_ready got %b exp 1", coef_wr_ready);
    end
  endtask

  task automatic test_pass(input logic [COEF_ADR_W-1:0] base, input logic log_en, input string name);
    logic [COEF_ADR_W-1:0]  exp_adr;
    logic [STATE_ADR_W-1:0] exp_sa;
    coef_base = base; log_enable = log_en; sample_tick = 1'b1;
    step();
    // Change the inputs after the tick: the pass must use the latched values.
    sample_tick = 1'b0; coef_base = 9'h0AA; log_enable = ~log_en;
    exp_adr = base;
    for (int c = 1; c <= 16; c++) begin
      if (c <= NUM_TAPS) exp_adr = base + COEF_ADR_W'(c - 1);
      tests_run++;
      if (slice_enable !== (c <= 13)) begin
        tests_failed++; $display("FAIL %s slice_enable c=%0d got %b exp %b", name, c, slice_enable, (c <= 13));
      end
      tests_run++;
      if (busy !== (c <= 14)) begin
        tests_failed++; $display("FAIL %s busy c=%0d got %b exp %b", name, c, busy, (c <= 14));
      end
      tests_run++;
      if (sigma_delta_out_trigger !== (c == 14)) begin
        tests_failed++; $display("FAIL %s trigger c=%0d got %b exp %b", name, c, sigma_delta_out_trigger, (c == 14));
      end
      tests_run++;
      if (log_trigger !== ((c == 14) && log_en)) begin
        tests_failed++; $display("FAIL %s log_trigger c=%0d got %b exp %b", name, c, log_trigger, ((c == 14) && log_en));
      end
      if (c <= 13) begin
        tests_run++;
        if (coefficient_read_adr !== exp_adr) begin
          tests_failed++; $display("FAIL %s coef_rd_adr c=%0d got %0d exp %0d", name, c, coefficient_read_adr, exp_adr);
        end
      end
      if (c >= 2 && c <= 11) begin
        exp_sa = STATE_ADR_W'(c - 2);
        tests_run++;
        if (state_read_adr !== exp_sa) begin
          tests_failed++; $display("FAIL %s state_rd_adr c=%0d got %0d exp %0d", name, c, state_read_adr, exp_sa);
        end
      end
      if (c >= 4 && c <= 13) begin
        exp_sa = STATE_ADR_W'(c - 4);
        tests_run++;
        if (state_write_adr !== exp_sa) begin
          tests_failed++; $display("FAIL %s state_wr_adr c=%0d got %0d exp %0d", name, c, state_write_adr, exp_sa);
        end
      end
      tests_run++;
      if (read_back !== 1'b0 || overrun !== 1'b0) begin
        tests_failed++; $display("FAIL %s rb_ovr c=%0d got %b%b exp 00", name, c, read_back, overrun);
      end
      step();
    end
  endtask

  task automatic test_overrun();
    do_reset();
    coef_base = '0; log_enable = 1'b0; sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 5) sample_tick = 1'b1;
      tests_run++;
      if (overrun !== (c >= 6)) begin
        tests_failed++; $display("FAIL ovr overrun c=%0d got %b exp %b", c, overrun, (c >= 6));
      end
      tests_run++;
      if (sigma_delta_out_trigger !== (c == 14)) begin
        tests_failed++; $display("FAIL ovr trigger c=%0d got %b exp %b", c, sigma_delta_out_trigger, (c == 14));
      end
      tests_run++;
      if (slice_enable !== (c <= 13)) begin
        tests_failed++; $display("FAIL ovr slice_enable c=%0d got %b exp %b", c, slice_enable, (c <= 13));
      end
      step();
      sample_tick = 1'b0;
    end
  endtask

  task automatic test_readback();
    logic                   exp_rb, exp_v;
    logic [STATE_ADR_W-1:0] exp_idx;
    logic [COEF_ADR_W-1:0]  exp_adr;
    do_reset();
    coef_base = 9'd100; readback_req = 1'b1;
    step();
    for (int c = 1; c <= 25; c++) begin
      exp_rb = (c >= 1 && c <= 10) || (c >= 12 && c <= 21);
      exp_v  = (c >= 3 && c <= 12) || (c >= 14 && c <= 23);
      exp_idx = (c <= 12) ? STATE_ADR_W'(c - 3) : STATE_ADR_W'(c - 14);
      exp_adr = (c <= 10) ? 9'd100 + COEF_ADR_W'(c - 1) : 9'd100 + COEF_ADR_W'(c - 12);
      tests_run++;
      if (read_back !== exp_rb) begin
        tests_failed++; $display("FAIL rb read_back c=%0d got %b exp %b", c, read_back, exp_rb);
      end
      tests_run++;
      if (rb_valid !== exp_v) begin
        tests_failed++; $display("FAIL rb rb_valid c=%0d got %b exp %b", c, rb_valid, exp_v);
      end
      if (exp_v) begin
        tests_run++;
        if (rb_index !== exp_idx) begin
          tests_failed++; $display("FAIL rb rb_index c=%0d got %0d exp %0d", c, rb_index, exp_idx);
        end
      end
      if (exp_rb) begin
        tests_run++;
        if (coefficient_read_adr !== exp_adr || coef_wr_ready !== 1'b0) begin
          tests_failed++; $display("FAIL rb adr_ready c=%0d got %0d/%b exp %0d/0", c, coefficient_read_adr, coef_wr_ready, exp_adr);
        end
      end
      tests_run++;
      if (slice_enable !== 1'b0 || rb_abort !== 1'b0 || busy !== exp_rb) begin
        tests_failed++; $display("FAIL rb ctrl c=%0d got se=%b ab=%b busy=%b exp 0 0 %b", c, slice_enable, rb_abort, busy, exp_rb);
      end
      if (c == 12) readback_req = 1'b0;
      step();
    end
  endtask

  task automatic test_abort();
    do_reset();
    coef_base = 9'd20; readback_req = 1'b1;
    step();
    readback_req = 1'b0;
    for (int c = 1; c <= 19; c++) begin
      if (c == 4) begin
        sample_tick = 1'b1; coef_base = 9'd40; log_enable = 1'b0;
      end
      tests_run++;
      if (read_back !== (c <= 4)) begin
        tests_failed++; $display("FAIL abort read_back c=%0d got %b exp %b", c, read_back, (c <= 4));
      end
      tests_run++;
      if (rb_valid !== (c == 3 || c == 4)) begin
        tests_failed++; $display("FAIL abort rb_valid c=%0d got %b exp %b", c, rb_valid, (c == 3 || c == 4));
      end
      tests_run++;
      if (rb_abort !== (c == 5)) begin
        tests_failed++; $display("FAIL abort rb_abort c=%0d got %b exp %b", c, rb_abort, (c == 5));
      end
      tests_run++;
      if (slice_enable !== (c >= 5 && c <= 17)) begin
        tests_failed++; $display("FAIL abort slice_enable c=%0d got %b exp %b", c, slice_enable, (c >= 5 && c <= 17));
      end
      tests_run++;
      if (overrun !== 1'b0 || sigma_delta_out_trigger !== (c == 18)) begin
        tests_failed++; $display("FAIL abort ovr_trig c=%0d got %b%b exp 0%b", c, overrun, sigma_delta_out_trigger, (c == 18));
      end
      if (c == 5 || c == 6) begin
        tests_run++;
        if (coefficient_read_adr !== 9'd40 + COEF_ADR_W'(c - 5)) begin
          tests_failed++; $display("FAIL abort coef_rd_adr c=%0d got %0d exp %0d", c, coefficient_read_adr, 40 + c - 5);
        end
      end
      step();
      sample_tick = 1'b0;
    end
  endtask

  task automatic test_host_write();
    logic [35:0] exp_data;
    exp_data = {18'sd400, 18'sd400};
    do_reset();
    coef_base = '0; log_enable = 1'b0;
    coef_wr_valid = 1'b1; coef_wr_adr = 9'd3; coef_wr_data = exp_data; sample_tick = 1'b1;
    #1;
    tests_run++;
    if (coef_wr_ready !== 1'b0) begin
      tests_failed++; $display("FAIL hw ready_with_tick got %b exp 0", coef_wr_ready);
    end
    step();
    sample_tick = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      tests_run++;
      if (coef_wr_ready !== (c == 15)) begin
        tests_failed++; $display("FAIL hw ready c=%0d got %b exp %b", c, coef_wr_ready, (c == 15));
      end
      tests_run++;
      if (coefficient_write_en !== 1'b0) begin
        tests_failed++; $display("FAIL hw write_en_early c=%0d got %b exp 0", c, coefficient_write_en);
      end
      if (c < 15) step();
    end
    step();
    coef_wr_valid = 1'b0;
    tests_run++;
    if (coefficient_write_en !== 1'b1 || coefficient_write_adr !== 9'd3 || coefficient_write_data !== exp_data) begin
      tests_failed++; $display("FAIL hw write got en=%b adr=%0d data=%h exp en=1 adr=3 data=%h",
                               coefficient_write_en, coefficient_write_adr, coefficient_write_data, exp_data);
    end
    tests_run++;
    if (slice_enable !== 1'b0 || read_back !== 1'b0) begin
      tests_failed++; $display("FAIL hw exclusive got se=%b rb=%b exp 0 0", slice_enable, read_back);
    end
    step();
    tests_run++;
    if (coefficient_write_en !== 1'b0) begin
      tests_failed++; $display("FAIL hw single_pulse got %b exp 0", coefficient_write_en);
    end
  endtask

  task automatic test_reset_mid_pass();
    do_reset();
    coef_base = 9'd7; log_enable = 1'b1; sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    for (int c = 1; c <= 7; c++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    tests_run++;
    if (out_vec() !== 78'd0) begin
      tests_failed++; $display("FAIL rst_mid outputs got %h exp 0", out_vec());
    end
    for (int c = 9; c <= 24; c++) begin
      tests_run++;
      if (sigma_delta_out_trigger !== 1'b0 || log_trigger !== 1'b0 || slice_enable !== 1'b0) begin
        tests_failed++; $display("FAIL rst_mid quiet c=%0d got %b%b%b exp 000", c, sigma_delta_out_trigger, log_trigger, slice_enable);
      end
      step();
    end
    coef_base = '0; log_enable = 1'b0; sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      tests_run++;
      if (coefficient_read_adr !== COEF_ADR_W'(c - 1) || slice_enable !== 1'b1) begin
        tests_failed++; $display("FAIL rst_mid fresh c=%0d got adr=%0d se=%b exp adr=%0d se=1", c, coefficient_read_adr, slice_enable, c - 1);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_pass(9'd0, 1'b0, "pass_base0");
    test_pass(9'd508, 1'b1, "pass_wrap");
    test_overrun();
    test_readback();
    test_abort();
    test_host_write();
    test_reset_mid_pass();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
